bcd_digit_sequencer: RTL and testbench

//  Converts a binary value into per-digit BCD codes for a row of digit_display

---
 rtl/bcd_digit_sequencer.sv | 164 ++++++++++++++++
 tb/tb_bcd_digit_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_sequencer.sv
// -----------------------------------------------------------------------------
// bcd_digit_sequencer
//   Converts a binary value into per-digit BCD codes for a row of digit
//   displays using sequential shift-add-3 (double dabble), one bit per clock.
//   The visible digits/blank/ovf registers change only at the commit edge, so
//   a video frame never shows a half-converted value.
//
// Parameters
//   WIDTH    bit width of the binary input value
//   DIGITS   number of BCD digits produced (digit 0 = least significant)
//   BLANK_LZ 1: flag leading zeros as blank; 0: blank is always all-zero
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   value_in    binary value, sampled on the accept edge
//   load_valid  request to convert value_in
//   load_ready  high in IDLE; accept = load_valid & load_ready
//   digits      committed BCD, [4i+3:4i] = digit i (all 4'hF on overflow)
//   blank       1 = digit i is a leading zero
//   busy        high while a conversion is in flight
//   done        one-cycle pulse after digits/blank/ovf update
//   ovf         last committed value did not fit in DIGITS
// -----------------------------------------------------------------------------
module bcd_digit_sequencer #(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 5,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      value_in,
   input  logic                  load_valid,
   output logic                  load_ready,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     blank,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   // Reset pattern: every digit but the least significant shows as blank.
   localparam logic [DIGITS-1:0] BLANK_RST = (BLANK_LZ != 0) ? ~DIGITS'(1) : '0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [WIDTH-1:0]      bin_q,  bin_d;
   logic [BW-1:0]         bcd_q,  bcd_d;
   logic                  sticky_q, sticky_d;
   logic [BW-1:0]         bcd_add;
   logic [BW-1:0]         digits_q;
   logic [DIGITS-1:0]     blank_q;
   logic                  ovf_q;
   logic                  done_q;

   // Add 3 to every nibble that is 5 or more, so the following shift carries
   // correctly into the next decimal digit.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
      end
      return r;
   endfunction

   // Leading-zero flags: digit i (i >= 1) is blank when it and every higher
   // digit are zero. Digit 0 always shows. No blanking on overflow.
   function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] b,
                                                  input logic          o);
      logic [DIGITS-1:0] r;
      logic              hi_zero;
      r       = '0;
      hi_zero = 1'b1;
      if (BLANK_LZ != 0 && !o) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero & (b[4*i +: 4] == 4'd0);
            r[i]    = hi_zero;
         end
      end
      return r;
   endfunction

   // Overflowed values render as all-segments-on ("8") in every position.
   function automatic logic [BW-1:0] saturate(input logic [BW-1:0] b,
                                              input logic          o);
      return o ? '1 : b;
   endfunction

   // One double-dabble step: add-3 correction, then shift {sticky,bcd,bin}
   // left. Whatever leaves the top nibble is remembered in the sticky bit.
   always_comb begin
      bcd_add  = add3(bcd_q);
      sticky_d = sticky_q | bcd_add[BW-1];
      bcd_d    = {bcd_add[BW-2:0], bin_q[WIDTH-1]};
      bin_d    = {bin_q[WIDTH-2:0], 1'b0};
   end

   assign load_ready = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign digits     = digits_q;
   assign blank      = blank_q;
   assign ovf        = ovf_q;
   assign done       = done_q;

   // Shift registers: loaded on accept, stepped while converting.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE) begin
         if (load_valid) begin
            bin_q    <= value_in;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
         end
      end else if (state_q == S_CONV) begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         sticky_q <= sticky_d;
      end
   end

   // Sequencer and committed outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         digits_q <= '0;
         blank_q  <= BLANK_RST;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load_valid) begin
                  cnt_q   <= CW'(WIDTH);
                  state_q <= S_CONV;
               end
            end
            S_CONV: begin
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= S_COMMIT;
            end
            S_COMMIT: begin
               digits_q <= saturate(bcd_q, sticky_q);
               blank_q  <= blank_of(bcd_q, sticky_q);
               ovf_q    <= sticky_q;
               done_q   <= 1'b1;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
module tb_bcd_digit_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   // 5-digit, leading-zero-blanking instance
   logic [15:0] value5 = '0;
   logic        lv5 = 1'b0;
   logic        ready5, busy5, done5, ovf5;
   logic [19:0] digits5;
   logic [4:0]  blank5;

   // 4-digit instance for overflow checks
   logic [15:0] value4 = '0;
   logic        lv4 = 1'b0;
   logic        ready4, busy4, done4, ovf4;
   logic [15:0] digits4;
   logic [3:0]  blank4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_digit_sequencer #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) dut5 (
      .clk(clk), .rst(rst), .value_in(value5), .load_valid(lv5),
      .load_ready(ready5), .digits(digits5), .blank(blank5),
      .busy(busy5), .done(done5), .ovf(ovf5));

   bcd_digit_sequencer #(.WIDTH(16), .DIGITS(4), .BLANK_LZ(1)) dut4 (
      .clk(clk), .rst(rst), .value_in(value4), .load_valid(lv4),
      .load_ready(ready4), .digits(digits4), .blank(blank4),
      .busy(busy4), .done(done4), .ovf(ovf4));

   // Reference: decimal digits by repeated /10, blank by magnitude, ovf by range.
   function automatic void model(input int v, input int nd,
                                 output logic [19:0] d, output logic [4:0] b,
                                 output logic o);
      int lim;
      int x;
      int pw;
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      o  = (v >= lim);
      d  = '0;
      b  = '0;
      x  = v;
      pw = 1;
      for (int i = 0; i < nd; i++) begin
         d[4*i +: 4] = o ? 4'hF : 4'(x % 10);
         if (i >= 1 && !o) b[i] = (v < pw);
         x  = x / 10;
         pw = pw * 10;
      end
   endfunction

   // Present v for one edge, then wait for done; lat = edges from accept to done.
   task automatic run5(input logic [15:0] v, output int lat);
      @(negedge clk); value5 = v; lv5 = 1'b1;
      @(negedge clk); lv5 = 1'b0;
      lat = 0;
      while (done5 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic run4(input logic [15:0] v, output int lat);
      @(negedge clk); value4 = v; lv4 = 1'b1;
      @(negedge clk); lv4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (digits5 !== 20'h0 || blank5 !== 5'b11110 || ready5 !== 1'b1 ||
          busy5 !== 1'b0 || done5 !== 1'b0 || ovf5 !== 1'b0) begin
         bad++;
         $display("FAIL reset5: got digits=%h blank=%b ready=%b busy=%b done=%b ovf=%b want 00000 11110 1 0 0 0",
                  digits5, blank5, ready5, busy5, done5, ovf5);
      end
      total++;
      if (digits4 !== 16'h0 || blank4 !== 4'b1110 || ready4 !== 1'b1 ||
          busy4 !== 1'b0 || done4 !== 1'b0 || ovf4 !== 1'b0) begin
         bad++;
         $display("FAIL reset4: got digits=%h blank=%b ready=%b busy=%b done=%b ovf=%b want 0000 1110 1 0 0 0",
                  digits4, blank4, ready4, busy4, done4, ovf4);
      end
   endtask

   task automatic test_basic();
      int lat;
      run5(16'd12345, lat);
      total++;
      if (lat !== 17) begin
         bad++; $display("FAIL latency: got %0d want 17", lat);
      end
      total++;
      if (digits5 !== 20'h12345 || blank5 !== 5'b0 || ovf5 !== 1'b0) begin
         bad++;
         $display("FAIL basic12345: got %h/%b/%b want 12345/00000/0", digits5, blank5, ovf5);
      end
      total++;
      if (ready5 !== 1'b1 || busy5 !== 1'b0) begin
         bad++; $display("FAIL done_idle: got ready=%b busy=%b want 1 0", ready5, busy5);
      end
      @(negedge clk);
      total++;
      if (done5 !== 1'b0 || digits5 !== 20'h12345) begin
         bad++; $display("FAIL done_pulse: got done=%b digits=%h want 0 12345", done5, digits5);
      end
   endtask

   task automatic test_values();
      logic [15:0] vals [3];
      logic [19:0] d;
      logic [4:0]  b;
      logic        o;
      int          lat;
      vals[0] = 16'd0; vals[1] = 16'd42; vals[2] = 16'd65535;
      for (int k = 0; k < 3; k++) begin
         run5(vals[k], lat);
         model(int'(vals[k]), 5, d, b, o);
         total++;
         if (lat !== 17 || digits5 !== d || blank5 !== b || ovf5 !== o) begin
            bad++;
            $display("FAIL value%0d: got lat=%0d %h/%b/%b want 17 %h/%b/%b",
                     vals[k], lat, digits5, blank5, ovf5, d, b, o);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk); value5 = 16'd123; lv5 = 1'b1;
      @(negedge clk); value5 = 16'd7;          // held while busy: must be ignored
      total++;
      if (busy5 !== 1'b1 || ready5 !== 1'b0) begin
         bad++; $display("FAIL busy_flags: got busy=%b ready=%b want 1 0", busy5, ready5);
      end
      lat = 0;
      while (done5 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      total++;
      if (lat !== 17 || digits5 !== 20'h00123 || blank5 !== 5'b11000) begin
         bad++;
         $display("FAIL ignore_busy: got lat=%0d %h/%b want 17 00123/11000", lat, digits5, blank5);
      end
      value5 = 16'd9;                         // offered during the done cycle
      @(negedge clk); lv5 = 1'b0;
      total++;
      if (busy5 !== 1'b1) begin
         bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy5);
      end
      lat = 0;
      while (done5 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      total++;
      if (lat !== 17 || digits5 !== 20'h00009 || blank5 !== 5'b11110 || ovf5 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_result: got lat=%0d %h/%b/%b want 17 00009/11110/0", lat, digits5, blank5, ovf5);
      end
      lat = 0;
      repeat (25) begin
         @(negedge clk);
         if (done5 === 1'b1 || busy5 === 1'b1) lat++;
      end
      total++;
      if (lat !== 0 || digits5 !== 20'h00009) begin
         bad++; $display("FAIL no_queue: got activity=%0d digits=%h want 0 00009", lat, digits5);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge clk); value5 = 16'd9999; lv5 = 1'b1;
      @(negedge clk); lv5 = 1'b0;            // accept edge E0 has passed
      repeat (7) @(negedge clk);             // now after E7
      rst = 1'b1;                             // sampled at E8
      @(negedge clk); rst = 1'b0;
      total++;
      if (busy5 !== 1'b0 || ready5 !== 1'b1 || done5 !== 1'b0 ||
          digits5 !== 20'h0 || blank5 !== 5'b11110 || ovf5 !== 1'b0) begin
         bad++;
         $display("FAIL abort: got busy=%b ready=%b done=%b %h/%b/%b want 0 1 0 00000/11110/0",
                  busy5, ready5, done5, digits5, blank5, ovf5);
      end
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (done5 === 1'b1) seen++;
      end
      total++;
      if (seen !== 0 || digits5 !== 20'h0) begin
         bad++; $display("FAIL abort_nodone: got pulses=%0d digits=%h want 0 00000", seen, digits5);
      end
   endtask

   task automatic test_overflow();
      int lat;
      run4(16'd10000, lat);
      total++;
      if (lat !== 17 || ovf4 !== 1'b1 || digits4 !== 16'hFFFF || blank4 !== 4'b0) begin
         bad++;
         $display("FAIL ovf10000: got lat=%0d %h/%b/%b want 17 ffff/0000/1", lat, digits4, blank4, ovf4);
      end
      run4(16'd9999, lat);
      total++;
      if (ovf4 !== 1'b0 || digits4 !== 16'h9999 || blank4 !== 4'b0) begin
         bad++;
         $display("FAIL edge9999: got %h/%b/%b want 9999/0000/0", digits4, blank4, ovf4);
      end
   endtask

   task automatic test_random4();
      logic [15:0] v;
      logic [19:0] d;
      logic [4:0]  b;
      logic        o;
      int          lat;
      for (int n = 0; n < 1000; n++) begin
         v = (n % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 10009));
         run4(v, lat);
         model(int'(v), 4, d, b, o);
         total++;
         if (lat !== 17 || digits4 !== d[15:0] || blank4 !== b[3:0] || ovf4 !== o) begin
            bad++;
            $display("FAIL rand4 v=%0d: got lat=%0d %h/%b/%b want 17 %h/%b/%b",
                     v, lat, digits4, blank4, ovf4, d[15:0], b[3:0], o);
         end
      end
   endtask

   task automatic test_random5();
      logic [15:0] v;
      logic [19:0] d;
      logic [4:0]  b;
      logic        o;
      int          lat;
      for (int n = 0; n < 200; n++) begin
         v = (n % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 999));
         run5(v, lat);
         model(int'(v), 5, d, b, o);
         total++;
         if (lat !== 17 || digits5 !== d || blank5 !== b || ovf5 !== o) begin
            bad++;
            $display("FAIL rand5 v=%0d: got lat=%0d %h/%b/%b want 17 %h/%b/%b",
                     v, lat, digits5, blank5, ovf5, d, b, o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_back_to_back();
      test_reset_abort();
      test_overflow();
      test_random4();
      test_random5();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
